cmp_minmax_sequencer: RTL and testbench

//  Sequences one shared 3-bit unsigned comparator to find the maximum and minimum of a frame of
//  1..MAX_LEN samples. It also reports the index of each.

---
 rtl/cmp_minmax_sequencer.sv | 155 +++++++++++++++
 tb/tb_cmp_minmax_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_minmax_sequencer.sv
// Frame max/min finder that time-shares one external unsigned comparator.
// Each sample after the first costs one accept cycle plus two compare cycles.
module cmp_minmax_sequencer #(
  parameter int WIDTH   = 3,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic             busy,
  output logic             done,
  output logic             err_len,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [LEN_W-1:0] max_idx,
  output logic [LEN_W-1:0] min_idx
);

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    WAIT,
    CMP_MAX,
    CMP_MIN,
    DONE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] lenQ;
  logic [LEN_W-1:0] cnt;
  logic [WIDTH-1:0] sampleQ;

  logic xfer;
  logic lenLegal;
  logic lastSample;

  assign xfer       = in_valid & in_ready;
  assign lenLegal   = (len != '0) && (len <= LEN_W'(MAX_LEN));
  assign lastSample = ((cnt + LEN_W'(1)) == lenQ);

  // Comparator operands are only meaningful in the two compare states.
  always_comb begin
    cmp_a = '0;
    cmp_b = '0;
    case (state)
      CMP_MAX: begin
        cmp_a = sampleQ;
        cmp_b = max_val;
      end
      CMP_MIN: begin
        cmp_a = sampleQ;
        cmp_b = min_val;
      end
      default: ;
    endcase
  end

  // NOTE: every register, results included, is cleared by the async reset so an
  // aborted frame leaves no stale max/min visible on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lenQ     <= '0;
      cnt      <= '0;
      sampleQ  <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_len  <= 1'b0;
      max_val  <= '0;
      min_val  <= '0;
      max_idx  <= '0;
      min_idx  <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every branch reads pre-edge values.
      done    <= 1'b0;
      err_len <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (lenLegal) begin
              lenQ     <= len;
              cnt      <= '0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              state    <= FIRST;
            end else begin
              err_len <= 1'b1;
            end
          end
        end
        FIRST: begin
          if (xfer) begin
            max_val <= in_data;
            min_val <= in_data;
            max_idx <= '0;
            min_idx <= '0;
            cnt     <= LEN_W'(1);
            if (lenQ == LEN_W'(1)) begin
              in_ready <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (xfer) begin
            sampleQ  <= in_data;
            in_ready <= 1'b0;
            state    <= CMP_MAX;
          end
        end
        CMP_MAX: begin
          // Strict compare: a tie keeps the earlier index.
          if (cmp_gt) begin
            max_val <= sampleQ;
            max_idx <= cnt;
          end
          state <= CMP_MIN;
        end
        CMP_MIN: begin
          if (cmp_lt) begin
            min_val <= sampleQ;
            min_idx <= cnt;
          end
          cnt <= cnt + LEN_W'(1);
          if (lastSample) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= WAIT;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_minmax_sequencer.sv
// Directed bench for cmp_minmax_sequencer with a behavioural comparator model.
module tb_cmp_minmax_sequencer;

  localparam int WIDTH = 3;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_gt;
  logic             cmp_lt;
  logic             busy;
  logic             done;
  logic             err_len;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] min_val;
  logic [LEN_W-1:0] max_idx;
  logic [LEN_W-1:0] min_idx;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] frameData [16];

  int doneCyc, doneCnt, errCnt, cmpSeen, busyAt1;

  always #5 clk = ~clk;

  // Shared comparator stand-in.
  assign cmp_gt = (cmp_a > cmp_b);
  assign cmp_lt = (cmp_a < cmp_b);

  cmp_minmax_sequencer #(.WIDTH(WIDTH), .MAX_LEN(8), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .cmp_a    (cmp_a),
    .cmp_b    (cmp_b),
    .cmp_gt   (cmp_gt),
    .cmp_lt   (cmp_lt),
    .busy     (busy),
    .done     (done),
    .err_len  (err_len),
    .max_val  (max_val),
    .min_val  (min_val),
    .max_idx  (max_idx),
    .min_idx  (min_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one frame from a start pulse. doneCyc is the cycle (start cycle = 0)
  // in which done is first seen. Stops early after abortAfter transfers.
  task automatic runFrame(input int lenIn, input int gapAfter, input int abortAfter,
                          input int restartCyc);
    int  idx;
    int  gap;
    logic xfer;
    idx     = 0;
    gap     = 0;
    doneCyc = 0;
    doneCnt = 0;
    errCnt  = 0;
    cmpSeen = 0;
    busyAt1 = 0;
    @(negedge clk);
    start    = 1'b1;
    len      = LEN_W'(lenIn);
    in_valid = 1'b1;
    in_data  = frameData[0];
    for (int cyc = 1; cyc <= 200; cyc++) begin
      xfer = in_valid && in_ready;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (cyc == 1) busyAt1 = int'(busy);
      if (done) begin
        doneCnt++;
        if (doneCyc == 0) doneCyc = cyc;
      end
      if (err_len) errCnt++;
      if (cmp_a != '0 || cmp_b != '0) cmpSeen = 1;
      if (xfer) begin
        idx++;
        if (idx - 1 == gapAfter) gap = 5;
      end
      if (abortAfter > 0 && idx == abortAfter) break;
      if (doneCyc != 0 && cyc >= doneCyc + 3) break;
      @(negedge clk);
      if (cyc == restartCyc) begin
        start = 1'b1;
        len   = LEN_W'(lenIn);
      end
      if (gap > 0) begin
        in_valid = 1'b0;
        gap--;
      end else begin
        in_valid = (idx < lenIn);
        in_data  = frameData[idx];
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_results", {max_val, min_val, max_idx, min_idx}, 0);
    check("rst_cmp", {cmp_a, cmp_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: len=4, data 3,6,1,6
    frameData[0] = 3'd3; frameData[1] = 3'd6; frameData[2] = 3'd1; frameData[3] = 3'd6;
    runFrame(4, -1, 0, -1);
    check("t1_done_cyc", doneCyc, 11);
    check("t1_done_cnt", doneCnt, 1);
    check("t1_busy", busyAt1, 1);
    check("t1_max", {max_val, max_idx}, {3'd6, 4'd1});
    check("t1_min", {min_val, min_idx}, {3'd1, 4'd2});
    check("t1_idle_busy", 32'(busy), 0);

    // 2: len=1, data 5
    frameData[0] = 3'd5;
    runFrame(1, -1, 0, -1);
    check("t2_done_cyc", doneCyc, 2);
    check("t2_cmp_quiet", cmpSeen, 0);
    check("t2_res", {max_val, min_val, max_idx, min_idx}, {3'd5, 3'd5, 4'd0, 4'd0});

    // 3: illegal lengths 0 and 9
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b1;
      len   = (k == 0) ? 4'd0 : 4'd9;
      @(posedge clk);
      #1;
      check("t3_err_pulse", 32'(err_len), 1);
      check("t3_ready_busy", {in_ready, busy}, 0);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check("t3_err_clear", 32'(err_len), 0);
      check("t3_ready_busy2", {in_ready, busy}, 0);
    end
    check("t3_res_kept", {max_val, min_val, max_idx, min_idx}, {3'd5, 3'd5, 4'd0, 4'd0});

    // 4: len=8, ramp 0..7 with 5 invalid cycles after sample 3
    for (int i = 0; i < 8; i++) frameData[i] = 3'(i);
    runFrame(8, 3, 0, -1);
    check("t4_done_cyc", doneCyc, 26);
    check("t4_done_cnt", doneCnt, 1);
    check("t4_max", {max_val, max_idx}, {3'd7, 4'd7});
    check("t4_min", {min_val, min_idx}, {3'd0, 4'd0});

    // 5: reset after 2 samples of a len=5 frame
    frameData[0] = 3'd4; frameData[1] = 3'd6; frameData[2] = 3'd1;
    frameData[3] = 3'd2; frameData[4] = 3'd3;
    runFrame(5, -1, 2, -1);
    check("t5_pre_rst_max", 32'(max_val), 4);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_ctl", {in_ready, busy, done, err_len}, 0);
    check("t5_rst_res", {max_val, min_val, max_idx, min_idx}, 0);
    check("t5_rst_cmp", {cmp_a, cmp_b}, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    doneCnt  = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (done) doneCnt++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("t5_no_done", doneCnt, 0);
    frameData[0] = 3'd2; frameData[1] = 3'd7; frameData[2] = 3'd4;
    runFrame(3, -1, 0, -1);
    check("t5_done_cyc", doneCyc, 8);
    check("t5_max", {max_val, max_idx}, {3'd7, 4'd1});
    check("t5_min", {min_val, min_idx}, {3'd2, 4'd0});

    // 6: ties plus a start pulse mid-frame
    frameData[0] = 3'd7; frameData[1] = 3'd7; frameData[2] = 3'd7;
    runFrame(3, -1, 0, 4);
    check("t6_done_cyc", doneCyc, 8);
    check("t6_done_cnt", doneCnt, 1);
    check("t6_no_err", errCnt, 0);
    check("t6_res", {max_val, min_val, max_idx, min_idx}, {3'd7, 3'd7, 4'd0, 4'd0});
    repeat (3) @(posedge clk);
    #1;
    check("t6_idle", {busy, in_ready, done}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
